reg2ahb_master: RTL and testbench

REG2AHB_MASTER -- requirements
Module: reg2ahb_master

---
 rtl/reg2ahb_master_if.sv | 44 ++++
 rtl/reg2ahb_master.sv | 140 ++++++++++++++
 tb/tb_reg2ahb_master.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg2ahb_master_if.sv
// Register-side request/response handshake plus AHB-Lite master bus, bundled for reg2ahb_master.
// The master modport is the bridge's view; the slave modport is the view of whatever surrounds it.
interface reg2ahb_master_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int WW = 4
) ();
    // register-side initiator
    logic          mreq;
    logic          mwrite;
    logic [AW-1:0] maddr;
    logic [WW-1:0] mstrb;
    logic [DW-1:0] mdata;
    logic          mready;
    logic          svalid;
    logic [DW-1:0] sdata;
    logic          sresp;

    // AHB-Lite
    logic [1:0]    htrans;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;

    modport master (
        input  mreq, mwrite, maddr, mstrb, mdata,
        output mready, svalid, sdata, sresp,
        output htrans, haddr, hwrite, hsize, hburst, hprot, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        output mreq, mwrite, maddr, mstrb, mdata,
        input  mready, svalid, sdata, sresp,
        input  htrans, haddr, hwrite, hsize, hburst, hprot, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/reg2ahb_master.sv
// Bridges single register-style requests onto AHB-Lite SINGLE transfers, one outstanding at a time.
// Byte strobes are translated into hsize plus the low byte-address bits.
module reg2ahb_master #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int WW = 4
) (
    input  logic                  hclk,
    input  logic                  hreset,
    reg2ahb_master_if.master      bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        LERR = 2'b11
    } state_t;

    state_t        state_reg;
    logic          mready_reg;
    logic          svalid_reg;
    logic [DW-1:0] sdata_reg;
    logic          sresp_reg;
    logic [1:0]    htrans_reg;
    logic [AW-1:0] haddr_reg;
    logic          hwrite_reg;
    logic [2:0]    hsize_reg;
    logic [DW-1:0] hwdata_reg;
    logic [DW-1:0] wdata_reg;
    logic          wr_reg;

    logic          dec_ok;
    logic [2:0]    dec_size;
    logic [1:0]    dec_off;
    logic [DW-1:0] hwdata_next;
    logic          unused_addr_bits;

    // Only naturally aligned byte, halfword and word lane patterns map to an AHB size.
    always_comb begin
        dec_ok   = 1'b1;
        dec_size = 3'b000;
        dec_off  = 2'b00;
        case (bus.mstrb)
            4'b0001: begin dec_size = 3'b000; dec_off = 2'b00; end
            4'b0010: begin dec_size = 3'b000; dec_off = 2'b01; end
            4'b0100: begin dec_size = 3'b000; dec_off = 2'b10; end
            4'b1000: begin dec_size = 3'b000; dec_off = 2'b11; end
            4'b0011: begin dec_size = 3'b001; dec_off = 2'b00; end
            4'b1100: begin dec_size = 3'b001; dec_off = 2'b10; end
            4'b1111: begin dec_size = 3'b010; dec_off = 2'b00; end
            default: dec_ok = 1'b0;
        endcase
    end

    // Writes drive the whole captured word on every lane; reads drive zero.
    generate
        for (genvar gi = 0; gi < WW; gi++) begin : g_wlane
            assign hwdata_next[gi*8 +: 8] = wr_reg ? wdata_reg[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign unused_addr_bits = ^bus.maddr[1:0];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg  <= IDLE;
            mready_reg <= 1'b1;
            svalid_reg <= 1'b0;
            sdata_reg  <= '0;
            sresp_reg  <= 1'b0;
            htrans_reg <= HTRANS_IDLE;
            haddr_reg  <= '0;
            hwrite_reg <= 1'b0;
            hsize_reg  <= 3'b000;
            hwdata_reg <= '0;
            wdata_reg  <= '0;
            wr_reg     <= 1'b0;
        end else begin
            svalid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.mreq) begin
                        mready_reg <= 1'b0;
                        wr_reg     <= bus.mwrite;
                        wdata_reg  <= bus.mdata;
                        if (dec_ok) begin
                            state_reg  <= ADDR;
                            htrans_reg <= HTRANS_NONSEQ;
                            haddr_reg  <= {bus.maddr[AW-1:2], dec_off};
                            hwrite_reg <= bus.mwrite;
                            hsize_reg  <= dec_size;
                        end else begin
                            state_reg <= LERR;
                        end
                    end
                end
                ADDR: begin
                    if (bus.hready) begin
                        state_reg  <= DATA;
                        htrans_reg <= HTRANS_IDLE;
                        hwdata_reg <= hwdata_next;
                    end
                end
                DATA: begin
                    // A two-cycle error response simply waits here until hready rises.
                    if (bus.hready) begin
                        state_reg  <= IDLE;
                        mready_reg <= 1'b1;
                        svalid_reg <= 1'b1;
                        sresp_reg  <= bus.hresp;
                        sdata_reg  <= wr_reg ? '0 : bus.hrdata;
                    end
                end
                LERR: begin
                    state_reg  <= IDLE;
                    mready_reg <= 1'b1;
                    svalid_reg <= 1'b1;
                    sresp_reg  <= 1'b1;
                    sdata_reg  <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mready = mready_reg;
    assign bus.svalid = svalid_reg;
    assign bus.sdata  = sdata_reg;
    assign bus.sresp  = sresp_reg;
    assign bus.htrans = htrans_reg;
    assign bus.haddr  = haddr_reg;
    assign bus.hwrite = hwrite_reg;
    assign bus.hsize  = hsize_reg;
    assign bus.hburst = 3'b000;
    assign bus.hprot  = 4'b0011;
    assign bus.hwdata = hwdata_reg;
endmodule

// File: tb/tb_reg2ahb_master.sv
// Directed bench for reg2ahb_master: stimulus pushes expected bus and response records into queues,
// and a negedge monitor pops and compares them whenever the DUT presents a transfer or a response.
module tb_reg2ahb_master;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    reg2ahb_master_if #(.AW(32), .DW(32), .WW(4)) bus ();

    reg2ahb_master #(.AW(32), .DW(32), .WW(4)) dut (
        .hclk   (clk),
        .hreset (rst),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        logic        err;
        logic        legal;
        logic [31:0] exp_haddr;
        logic [2:0]  exp_size;
        logic [31:0] exp_sdata;
        logic        exp_sresp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] sdata;
        logic        sresp;
        int          cyc;
    } rsp_t;

    typedef struct {
        string       name;
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] wdata;
    } ap_t;

    rsp_t rsp_q[$];
    ap_t  ap_q[$];
    vec_t vecs[10];

    logic        dp_active;
    logic [31:0] dp_wdata;
    string       dp_name;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: response strobes, data-phase hwdata, and address-phase attributes.
    always @(negedge clk) begin
        if (rst) begin
            dp_active = 1'b0;
        end else begin
            if (bus.svalid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_svalid", 32'(bus.svalid), 32'h0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk({r.name, "_sdata"}, bus.sdata, r.sdata);
                    chk({r.name, "_sresp"}, 32'(bus.sresp), 32'(r.sresp));
                    chk({r.name, "_latency_cycle"}, 32'(cyc), 32'(r.cyc));
                    chk({r.name, "_mready_with_svalid"}, 32'(bus.mready), 32'h1);
                    $display("rsp %s sdata=%h sresp=%0d cycle=%0d", r.name, bus.sdata, bus.sresp, cyc);
                end
            end
            if (dp_active) begin
                chk({dp_name, "_hwdata"}, bus.hwdata, dp_wdata);
                chk({dp_name, "_htrans_data"}, 32'(bus.htrans), 32'h0);
                if (bus.hready) dp_active = 1'b0;
            end
            if (bus.htrans == 2'b10) begin
                if (ap_q.size() == 0) begin
                    chk("unexpected_nonseq", 32'(bus.htrans), 32'h0);
                end else begin
                    ap_t a;
                    a = ap_q[0];
                    chk({a.name, "_haddr"}, bus.haddr, a.haddr);
                    chk({a.name, "_hwrite"}, 32'(bus.hwrite), 32'(a.hwrite));
                    chk({a.name, "_hsize"}, 32'(bus.hsize), 32'(a.hsize));
                    chk({a.name, "_hburst"}, 32'(bus.hburst), 32'h0);
                    chk({a.name, "_hprot"}, 32'(bus.hprot), 32'h3);
                    if (bus.hready) begin
                        void'(ap_q.pop_front());
                        dp_active = 1'b1;
                        dp_wdata  = a.hwrite ? a.wdata : 32'h0;
                        dp_name   = a.name;
                    end
                end
            end
        end
    end

    task automatic wait_mready();
        int n;
        n = 0;
        while (bus.mready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.mready !== 1'b1) chk("mready_timeout", 32'(bus.mready), 32'h1);
    endtask

    task automatic run_vec(input vec_t v);
        int acc;
        rsp_t r;
        ap_t  a;
        wait_mready();
        acc = cyc + 1;
        r.name  = v.name;
        r.sdata = v.exp_sdata;
        r.sresp = v.exp_sresp;
        r.cyc   = v.legal ? acc + 2 + v.aw + v.dw : acc + 1;
        rsp_q.push_back(r);
        if (v.legal) begin
            a.name   = v.name;
            a.haddr  = v.exp_haddr;
            a.hwrite = v.wr;
            a.hsize  = v.exp_size;
            a.wdata  = v.data;
            ap_q.push_back(a);
        end
        $display("req %s wr=%0d addr=%h strb=%b data=%h", v.name, v.wr, v.addr, v.strb, v.data);
        bus.mreq   = 1'b1;
        bus.mwrite = v.wr;
        bus.maddr  = v.addr;
        bus.mstrb  = v.strb;
        bus.mdata  = v.data;
        bus.hready = 1'b1;
        @(posedge clk); #1;
        // Changed inputs plus a request while busy: both must be ignored.
        bus.mreq   = 1'b1;
        bus.mwrite = ~v.wr;
        bus.maddr  = ~v.addr;
        bus.mstrb  = 4'b1111;
        bus.mdata  = ~v.data;
        if (!v.legal) begin
            @(posedge clk); #1;
            bus.mreq = 1'b0;
            return;
        end
        repeat (v.aw) begin
            bus.hready = 1'b0;
            @(posedge clk); #1;
            bus.mreq = 1'b0;
        end
        bus.hready = 1'b1;
        @(posedge clk); #1;
        bus.mreq   = 1'b0;
        bus.hrdata = v.rdata;
        repeat (v.dw) begin
            bus.hready = 1'b0;
            bus.hresp  = v.err;
            @(posedge clk); #1;
        end
        bus.hready = 1'b1;
        bus.hresp  = v.err;
        @(posedge clk); #1;
        bus.hresp  = 1'b0;
        bus.hrdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        dp_active = 1'b0;
        rst = 1'b1;
        bus.mreq = 1'b0; bus.mwrite = 1'b0; bus.maddr = 32'h0; bus.mstrb = 4'h0; bus.mdata = 32'h0;
        bus.hrdata = 32'h0; bus.hready = 1'b1; bus.hresp = 1'b0;

        //          name            wr    addr          strb     data          rdata         aw dw err   legal exp_haddr     size    exp_sdata     sresp
        vecs[0] = '{"rd_word",      1'b0, 32'h00000100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0, 1'b0, 1'b1, 32'h00000100, 3'b010, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{"wr_byte2",     1'b1, 32'h00000203, 4'b0100, 32'h00AB0000, 32'h0,        0, 0, 1'b0, 1'b1, 32'h00000202, 3'b000, 32'h0,        1'b0};
        vecs[2] = '{"rd_half_wait", 1'b0, 32'h00000344, 4'b0011, 32'h0,        32'h12345678, 2, 1, 1'b0, 1'b1, 32'h00000344, 3'b001, 32'h12345678, 1'b0};
        vecs[3] = '{"wr_err",       1'b1, 32'h0000040C, 4'b1000, 32'hCAFEF00D, 32'h0,        0, 1, 1'b1, 1'b1, 32'h0000040F, 3'b000, 32'h0,        1'b1};
        vecs[4] = '{"rd_after_err", 1'b0, 32'h00000010, 4'b0010, 32'h0,        32'h55AA33CC, 0, 0, 1'b0, 1'b1, 32'h00000011, 3'b000, 32'h55AA33CC, 1'b0};
        vecs[5] = '{"ill_0101",     1'b1, 32'h00000080, 4'b0101, 32'hFFFFFFFF, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        3'b000, 32'h0,        1'b1};
        vecs[6] = '{"ill_0000",     1'b0, 32'h00000084, 4'b0000, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        3'b000, 32'h0,        1'b1};
        vecs[7] = '{"wr_half_hi",   1'b1, 32'h000007FC, 4'b1100, 32'h11223344, 32'h0,        1, 0, 1'b0, 1'b1, 32'h000007FE, 3'b001, 32'h0,        1'b0};
        vecs[8] = '{"rd_err_top",   1'b0, 32'hFFFFFFFF, 4'b0001, 32'h0,        32'h0BADF00D, 0, 0, 1'b1, 1'b1, 32'hFFFFFFFC, 3'b000, 32'h0BADF00D, 1'b1};
        vecs[9] = '{"ill_0111",     1'b0, 32'h00000088, 4'b0111, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        3'b000, 32'h0,        1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mready", 32'(bus.mready), 32'h1);
        chk("reset_svalid", 32'(bus.svalid), 32'h0);
        chk("reset_htrans", 32'(bus.htrans), 32'h0);
        chk("reset_haddr", bus.haddr, 32'h0);
        chk("reset_hwdata", bus.hwdata, 32'h0);
        chk("reset_sdata", bus.sdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset while stalled in the data phase: no response may ever appear for this request.
        wait_mready();
        begin
            ap_t a;
            a.name = "rd_reset"; a.haddr = 32'h00000500; a.hwrite = 1'b0; a.hsize = 3'b010; a.wdata = 32'h0;
            ap_q.push_back(a);
        end
        $display("req rd_reset wr=0 addr=00000500 strb=1111 (aborted by reset)");
        bus.mreq = 1'b1; bus.mwrite = 1'b0; bus.maddr = 32'h500; bus.mstrb = 4'b1111;
        @(posedge clk); #1;
        bus.mreq = 1'b0;
        @(posedge clk); #1;
        bus.hready = 1'b0;
        bus.hrdata = 32'h77777777;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_mready", 32'(bus.mready), 32'h1);
        chk("rst_mid_htrans", 32'(bus.htrans), 32'h0);
        chk("rst_mid_svalid", 32'(bus.svalid), 32'h0);
        chk("rst_mid_sresp", 32'(bus.sresp), 32'h0);
        rst = 1'b0;
        bus.hready = 1'b1;
        bus.hrdata = 32'h0;
        repeat (4) @(posedge clk);
        #1;

        run_vec(vecs[0]);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
        chk("addr_queue_drained", 32'(ap_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
